seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
- Parametrised, runtime-programmable serial pattern detector. Successor to the fixed 4-bit "1011" Moore detector.
- Matches a configurable pattern of 1..MAX_LEN bits on a qualified serial stream.
- Supports overlapping and non-overlapping modes and keeps a saturating detection counter.
- Sits on the serial front-end next to the deserialiser and feeds frame-sync and status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the detection counter.
- DEF_PATTERN, 'b1011, pattern loaded at reset (right-aligned).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the clock edge).
- cfg_we  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length. Legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  clear det_count.
- in_valid  in  1  seq_in is valid this cycle.
- seq_in  in  1  serial data bit.
- det_o  out  1  one-cycle detection pulse, registered.
- det_count  out  CNT_W  saturating count of detections.
- cfg_err  out  1  one-cycle pulse: illegal cfg_len was rejected.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Load pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - Clear hist, fill and state (state=FILL).
  - Drive det_o=0, det_count=0, cfg_err=0.
  - Reset overrides every other input.
- Internal state:
  - hist[MAX_LEN-1:0]: shift register. On an accepted bit, hist <= {hist[MAX_LEN-2:0], seq_in}.
  - fill: count of bits accepted since the last reset, config load or non-overlap match. Saturates at MAX_LEN.
  - FSM with two states:
    - FILL (fill<len): no match is possible.
    - ARMED (fill>=len): matching is enabled.
  - FILL->ARMED when the accepted bit makes fill reach len.
  - ARMED->FILL on a config load, or on a match in non-overlap mode.
- A bit is accepted when in_valid==1 and cfg_we==0.
- Match condition, evaluated on the post-shift history: (fill+1)>=len and hist_next[len-1:0]==pattern[len-1:0]. Bits above len are ignored.
- Latency: det_o=1 in the cycle after the clock edge that accepts the final bit of the match, and is high for exactly one cycle. det_o=0 in every cycle with no match, including in_valid gaps. Idle cycles (in_valid=0) do not disturb hist or fill.
- Overlap=1: after a match, fill is kept and the FSM stays ARMED. Example: pattern 1011 over stream 1011011 gives 2 matches.
- Overlap=0: after a match, fill<=0 and the FSM goes to FILL. The next match needs len fresh bits.
- det_count increments by 1 on each match and saturates at 2^CNT_W-1.
- cnt_clr:
  - det_count<=0 on the next edge.
  - If cnt_clr and a match occur together, det_count<=1.
- cfg_we:
  - cfg_len in 1..MAX_LEN: load pattern, len and overlap; clear hist and fill; state=FILL; the det_o of the next cycle is 0. det_count is unchanged.
  - Any in_valid bit in the same cycle is discarded.
  - cfg_len==0 or cfg_len>MAX_LEN: config is unchanged, hist and fill are untouched, cfg_err=1 for one cycle. The same-cycle bit is still discarded.
- len==1: every accepted bit equal to pattern[0] is a match, in either mode.
- No X propagation: all registers are reset. The FSM default branch returns to FILL.

Test Plan:
- Reset defaults, stream 1,0,1,1,0,1,1 (in_valid=1 throughout) -> det_o pulses in the cycles after bits 4 and 7; det_count=2.
- cfg pattern=2'b11, len=2, overlap=0, stream 1,1,1,1 -> 2 pulses, after bits 2 and 4. Repeat with overlap=1 -> 3 pulses, after bits 2, 3 and 4.
- Default config, stream 1,0,1 then in_valid=0 for 5 cycles then bit 1 -> a single pulse one cycle after the final bit; no pulse during the gap.
- Mid-stream cfg_we (pattern 8'hA5, len=8) after bits 1,0,1 with in_valid=1 in that cycle -> that bit is dropped, fill=0, no pulse; then stream A5 MSB-first -> 1 pulse.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; config is unchanged and the default 1011 still detects.
- CNT_W=2, 5 matches -> det_count sequence 1,2,3,3,3. Then cnt_clr coincident with a match -> det_count=1. Then reset=0 mid-pattern for one cycle -> all outputs are 0 and the partial match is forgotten.

Source files
------------

// File: rtl/seq_det_prog.sv
// ----------------------------------------------------------------------------
// seq_det_prog
//   Runtime-programmable serial pattern detector. Watches a qualified serial
//   bit stream and raises a one-cycle registered pulse whenever the most
//   recent len accepted bits equal the programmed pattern (first received bit
//   at pattern[len-1], last at pattern[0]). Overlapping or non-overlapping
//   matching is selectable, and a saturating counter tracks detections.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous active-low reset
//   cfg_we       in   load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  in   pattern, right-aligned (MAX_LEN bits)
//   cfg_len      in   pattern length, legal 1..MAX_LEN
//   cfg_overlap  in   1 = overlapping matches allowed
//   cnt_clr      in   clear det_count
//   in_valid     in   seq_in is valid this cycle
//   seq_in       in   serial data bit
//   det_o        out  one-cycle detection pulse (registered)
//   det_count    out  saturating detection count
//   cfg_err      out  one-cycle pulse when an illegal cfg_len is rejected
// ----------------------------------------------------------------------------
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
    parameter int                 DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic               seq_in,
    output logic               det_o,
    output logic [CNT_W-1:0]   det_count,
    output logic               cfg_err
);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment of the fill level, capped at MAX_LEN.
    function automatic logic [LEN_W-1:0] fill_sat_inc(input logic [LEN_W-1:0] v);
        if (v >= LEN_MAX) begin
            return LEN_MAX;
        end
        return v + LEN_W'(1);
    endfunction

    // Saturating increment of the detection counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end
        return v + CNT_W'(1);
    endfunction

    // Registered state
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    state_t             r_state;
    logic               r_det;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    // Next-state values
    logic [MAX_LEN-1:0] w_pattern_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_overlap_nxt;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;
    state_t             w_state_nxt;
    logic               w_det_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_err_nxt;

    // Datapath helpers
    logic               w_accept;
    logic               w_cfg_ok;
    logic [MAX_LEN-1:0] w_hist_shift;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_reach;
    logic               w_eq;
    logic               w_match;

    // A config write always steals the cycle, so a same-cycle bit is dropped.
    assign w_accept     = in_valid & ~cfg_we;
    assign w_cfg_ok     = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    assign w_hist_shift = {r_hist[MAX_LEN-2:0], seq_in};
    assign w_fill_inc   = fill_sat_inc(r_fill);

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < r_len) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_reach = (w_fill_inc >= r_len);
    assign w_eq    = (((w_hist_shift ^ r_pattern) & w_mask) == '0);
    // ARMED already implies enough history; in FILL the incoming bit may
    // complete the window, which is what w_reach covers.
    assign w_match = w_accept && ((r_state == ST_ARMED) || w_reach) && w_eq;

    // Next-state / output logic
    always_comb begin
        w_pattern_nxt = r_pattern;
        w_len_nxt     = r_len;
        w_overlap_nxt = r_overlap;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_state_nxt   = r_state;
        w_det_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_count_nxt   = r_count;

        if (cfg_we) begin
            if (w_cfg_ok) begin
                w_pattern_nxt = cfg_pattern;
                w_len_nxt     = cfg_len;
                w_overlap_nxt = cfg_overlap;
                w_hist_nxt    = '0;
                w_fill_nxt    = '0;
                w_state_nxt   = ST_FILL;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (in_valid) begin
            w_hist_nxt = w_hist_shift;
            w_fill_nxt = w_fill_inc;
            case (r_state)
                ST_FILL:  w_state_nxt = w_reach ? ST_ARMED : ST_FILL;
                ST_ARMED: w_state_nxt = ST_ARMED;
                default:  w_state_nxt = ST_FILL;
            endcase
            if (w_match) begin
                w_det_nxt = 1'b1;
                // Non-overlap: the next match must be built from fresh bits.
                if (!r_overlap) begin
                    w_fill_nxt  = '0;
                    w_state_nxt = ST_FILL;
                end
            end
        end else begin
            case (r_state)
                ST_FILL, ST_ARMED: w_state_nxt = r_state;
                default:           w_state_nxt = ST_FILL;
            endcase
        end

        // A clear coincident with a match still records that match.
        if (cnt_clr) begin
            w_count_nxt = w_match ? CNT_W'(1) : '0;
        end else if (w_match) begin
            w_count_nxt = cnt_sat_inc(r_count);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= ST_FILL;
            r_det     <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pattern <= w_pattern_nxt;
            r_len     <= w_len_nxt;
            r_overlap <= w_overlap_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_state   <= w_state_nxt;
            r_det     <= w_det_nxt;
            r_count   <= w_count_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign det_o     = r_det;
    assign det_count = r_count;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_det_prog.sv
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               seq_in = 1'b0;

    logic               det_o, det_o2;
    logic [7:0]         det_count;
    logic [1:0]         det_count2;
    logic               cfg_err, cfg_err2;

    seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .seq_in(seq_in),
        .det_o(det_o), .det_count(det_count), .cfg_err(cfg_err)
    );

    seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .seq_in(seq_in),
        .det_o(det_o2), .det_count(det_count2), .cfg_err(cfg_err2)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: pattern as received-order bit list, recent bits queue.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_q[$];
    bit         m_det;
    bit         m_err;
    int         m_cnt8;
    int         m_cnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat  = 8'b0000_1011;
        m_len  = 4;
        m_ov   = 1'b1;
        m_q.delete();
        m_det  = 1'b0;
        m_err  = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic step(input bit we, input int pat, input int len, input bit ov,
                        input bit clr, input bit v, input bit b, input bit rst_n);
        bit match;
        cfg_we      = we;
        cfg_pattern = pat[7:0];
        cfg_len     = len[3:0];
        cfg_overlap = ov;
        cnt_clr     = clr;
        in_valid    = v;
        seq_in      = b;
        reset       = rst_n;
        @(posedge clock);
        match = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            if (we) begin
                if (len >= 1 && len <= MAX_LEN) begin
                    m_pat = pat[7:0];
                    m_len = len;
                    m_ov  = ov;
                    m_q.delete();
                end else begin
                    m_err = 1'b1;
                end
            end else if (v) begin
                m_q.push_back(b);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    match = 1'b1;
                    // Last received bit is pattern[0], len-th most recent is pattern[len-1].
                    for (int i = 0; i < m_len; i++)
                        if (m_q[m_q.size() - 1 - i] != m_pat[i]) match = 1'b0;
                end
                if (match && !m_ov) m_q.delete();
            end
            m_det = match;
            if (clr) begin
                m_cnt8 = match ? 1 : 0;
                m_cnt2 = match ? 1 : 0;
            end else if (match) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
        #1;
        chk("det_o",      32'(det_o),      32'(m_det));
        chk("det_count",  32'(det_count),  32'(m_cnt8));
        chk("cfg_err",    32'(cfg_err),    32'(m_err));
        chk("det_o2",     32'(det_o2),     32'(m_det));
        chk("det_count2", 32'(det_count2), 32'(m_cnt2));
        chk("cfg_err2",   32'(cfg_err2),   32'(m_err));
    endtask

    task automatic bit_in(input bit b);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, b, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cfg(input int pat, input int len, input bit ov);
        step(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic clr();
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [6:0] s1;
        logic [7:0] a5;
        model_reset();

        // Reset state
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_det",   32'(det_o),     32'd0);
        chk("rst_count", 32'(det_count), 32'd0);

        // Default 1011 over 1011011: pulses after bits 4 and 7
        s1 = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            if (i == 3 || i == 0) chk("t1_pulse", 32'(det_o), 32'd1);
        end
        chk("t1_total", 32'(det_count), 32'd2);

        // 11, non-overlap then overlap
        clr();
        cfg(2'b11, 2, 1'b0);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        chk("t2_nov", 32'(det_count), 32'd2);
        clr();
        cfg(2'b11, 2, 1'b1);
        for (int i = 0; i < 4; i++) bit_in(1'b1);
        chk("t2_ov", 32'(det_count), 32'd3);

        // Idle gap in the middle of a match
        cfg(4'b1011, 4, 1'b1);
        clr();
        bit_in(1); bit_in(0); bit_in(1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t3_gap", 32'(det_o), 32'd0);
        end
        bit_in(1);
        chk("t3_pulse", 32'(det_o), 32'd1);

        // Mid-stream config with a same-cycle bit
        clr();
        bit_in(1); bit_in(0); bit_in(1);
        step(1'b1, 8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) bit_in(a5[i]);
        chk("t4_a5", 32'(det_count), 32'd1);

        // Illegal lengths rejected, old config kept
        cfg(4'b1011, 4, 1'b1);
        cfg(8'hFF, 0, 1'b0);
        chk("t5_err0", 32'(cfg_err), 32'd1);
        cfg(8'hFF, 9, 1'b0);
        chk("t5_err9", 32'(cfg_err), 32'd1);
        clr();
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("t5_det", 32'(det_o), 32'd1);

        // Saturation on the 2-bit counter, clear with match, reset mid-pattern
        clr();
        cfg(1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_in(1);
            chk("t6_sat", 32'(det_count2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_clrmatch", 32'(det_count2), 32'd1);
        cfg(4'b1011, 4, 1'b1);
        bit_in(1); bit_in(0); bit_in(1);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_rst_cnt", 32'(det_count), 32'd0);
        bit_in(1);
        chk("t6_forget", 32'(det_o), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 10)), 1'($urandom));
            end else if (r < 3) begin
                step(1'b0, 0, 0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end else if (r < 5) begin
                step(1'b0, 0, 0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b1);
            end else if (r < 10) begin
                cfg(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'($urandom));
            end else if (r < 30) begin
                idle();
            end else begin
                bit_in(1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
